led_blink_ctrl: RTL
===================

Name: led_blink_ctrl

Overview:
Multi-channel LED blink controller. It is the parametrised successor to the single-LED fixed-period toggle counter.
- A shared prescaler derives a slow tick from the system clock.
- Each of CH_NUM channels has its own mode (OFF/ON/BLINK/ONESHOT) and half-period, counted in ticks.
- Channels are configured at runtime through a valid/ready write port.
- The block sits between board-level control logic and the LED pins.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz
TICK_HZ, 1_000, prescaler tick rate in Hz; must divide CLK_FREQ_HZ, and CLK_FREQ_HZ/TICK_HZ >= 2
CH_NUM, 4, number of LED channels (1..16)
PERIOD_W, 16, width of the per-channel half-period and tick counter
CH_W, clog2(CH_NUM) with a minimum of 1, derived width of the channel index

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
sys_rst  in  1  reset
cfg_valid  in  1  config write request
cfg_ready  out  1  block can accept a config write
cfg_ch  in  CH_W  target channel index
cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
cfg_half_period  in  PERIOD_W  half-period in ticks
tick_out  out  1  one-cycle pulse per prescaler tick
led_out  out  CH_NUM  LED drive, bit i = channel i, active-high

Interface (already decided): one clock, sys_clk; reset sys_rst is synchronous and active-high.

Behaviour:
- Reset (sys_rst=1 at a rising edge) forces, at that edge:
  - pre_cnt=0, tick_out=0, cfg_ready=0
  - every channel: mode=OFF, half_period=1, cnt=0, led_out=0
- Reset mid-operation aborts everything immediately; there is no pending state.
- cfg_ready is registered:
  - it goes to 1 on the first edge with sys_rst=0 and stays 1 until the next reset.
- Prescaler:
  - PRE_MAX = CLK_FREQ_HZ/TICK_HZ - 1; pre_cnt counts 0..PRE_MAX and wraps to 0.
  - tick_out is registered: it is 1 for exactly the cycle after pre_cnt==PRE_MAX.
  - First tick_out is PRE_MAX+1 cycles after reset release; the period is then exactly PRE_MAX+1 cycles.
- Config write:
  - Accepted when cfg_valid && cfg_ready at a rising edge.
  - On that edge the target channel loads mode and half_period and clears cnt to 0.
  - A cfg_half_period of 0 is stored as 1.
  - led_out[ch] takes its initial value on the same edge (1-cycle latency, visible the cycle after accept): OFF→0, ON→1, BLINK→1, ONESHOT→1.
  - If cfg_ch >= CH_NUM, the write is accepted (handshake completes) but has no effect.
- Per-channel operation, evaluated at each rising edge where the internal tick is high:
  - OFF / ON: led_out is held at 0 / 1; cnt is unused.
  - BLINK:
    - If cnt == half_period-1: led_out toggles and cnt goes to 0.
    - Else: cnt increments.
    - LED is high for half_period ticks, then low for half_period ticks, repeating.
  - ONESHOT:
    - If cnt == half_period-1: led_out goes to 0, mode goes to OFF, cnt goes to 0.
    - Else: cnt increments.
    - LED is high for exactly half_period ticks after the write, then stays off.
- The tick phase is not realigned by a config write. The first counted tick is the next one after the accept edge, so the first phase lasts between (half_period-1)×(PRE_MAX+1)+1 and half_period×(PRE_MAX+1) cycles.
- Simultaneous write and tick to the same channel: the write wins and the tick is ignored for that channel only; other channels process the tick normally.
- Counters cannot overflow: cnt <= half_period-1 at all times, because width is PERIOD_W and half_period is at most 2^PERIOD_W-1.

Test Plan:
Bench parameters: CLK_FREQ_HZ=100, TICK_HZ=10 (PRE_MAX=9), CH_NUM=4, PERIOD_W=8.
1. Hold sys_rst 3 cycles, release → led_out=4'b0000 throughout reset, cfg_ready=1 one cycle after release, first tick_out 10 cycles after release, then every 10 cycles, each pulse 1 cycle wide.
2. Write ch0 BLINK half=3 → led_out[0]=1 the cycle after accept; it then toggles on every 3rd tick_out (every 30 cycles) for at least 4 toggles; other bits stay 0.
3. Write ch2 ONESHOT half=2 → led_out[2]=1 from the cycle after accept until the 2nd subsequent tick, then 0 permanently with no further activity over 100 cycles.
4. Write ch1 BLINK half=0 → behaves as half=1, so led_out[1] toggles on every tick_out. Then write ch1 ON in the same cycle that tick_out=1 → led_out[1]=1 and held, with no toggle from that tick.
5. With ch0 blinking, write cfg_ch=5 (out of range) with cfg_ch widened in the bench → handshake completes, and led_out and ch0 timing are unchanged.
6. Assert sys_rst for 1 cycle mid-blink on ch0 and ch3 → at that edge led_out=0 and cfg_ready=0. After release, no LED activity occurs until a new write, and the tick restarts with 10-cycle latency.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared tick prescaler, per-channel mode
// and half-period, runtime configuration through a valid/ready write port.
//
// mode         | meaning
// MODE_OFF     | LED held low, counter idle
// MODE_ON      | LED held high, counter idle
// MODE_BLINK   | LED toggles every half_period ticks
// MODE_ONESHOT | LED high for half_period ticks, then falls back to MODE_OFF
module led_blink_ctrl #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1_000,
  parameter int CH_NUM      = 4,
  parameter int PERIOD_W    = 16,
  parameter int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half_period,
  output logic                tick_out,
  output logic [CH_NUM-1:0]   led_out
);

  localparam int PRE_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic                r_tick;
  logic                r_cfg_ready;

  mode_t               r_mode     [CH_NUM];
  mode_t               w_mode_nxt [CH_NUM];
  logic [PERIOD_W-1:0] r_half     [CH_NUM];
  logic [PERIOD_W-1:0] w_half_nxt [CH_NUM];
  logic [PERIOD_W-1:0] r_cnt      [CH_NUM];
  logic [PERIOD_W-1:0] w_cnt_nxt  [CH_NUM];
  logic [CH_NUM-1:0]   r_led;
  logic [CH_NUM-1:0]   w_led_nxt;

  logic                w_cfg_fire;
  logic [PERIOD_W-1:0] w_cfg_half;

  assign w_cfg_fire = cfg_valid && r_cfg_ready;
  // A zero half-period would never terminate a phase, so it is promoted to 1.
  assign w_cfg_half = (cfg_half_period == '0) ? PERIOD_W'(1) : cfg_half_period;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pre_cnt   <= '0;
      r_tick      <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
      if (r_pre_cnt == PRE_W'(PRE_MAX)) begin
        r_pre_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
        r_tick    <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_mode[i] <= MODE_OFF;
        r_half[i] <= PERIOD_W'(1);
        r_cnt[i]  <= '0;
      end
      r_led <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_half[i] <= w_half_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
      r_led <= w_led_nxt;
    end
  end

  // A write to a channel takes priority over a coincident tick on that channel.
  always_comb begin
    w_led_nxt = r_led;
    for (int i = 0; i < CH_NUM; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_half_nxt[i] = r_half[i];
      w_cnt_nxt[i]  = r_cnt[i];
      if (w_cfg_fire && (int'(cfg_ch) == i)) begin
        w_mode_nxt[i] = mode_t'(cfg_mode);
        w_half_nxt[i] = w_cfg_half;
        w_cnt_nxt[i]  = '0;
        w_led_nxt[i]  = (mode_t'(cfg_mode) != MODE_OFF);
      end else if (r_tick) begin
        case (r_mode[i])
          MODE_OFF: w_led_nxt[i] = 1'b0;
          MODE_ON:  w_led_nxt[i] = 1'b1;
          MODE_BLINK: begin
            if (r_cnt[i] == r_half[i] - 1'b1) begin
              w_led_nxt[i] = ~r_led[i];
              w_cnt_nxt[i] = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
          MODE_ONESHOT: begin
            if (r_cnt[i] == r_half[i] - 1'b1) begin
              w_led_nxt[i]  = 1'b0;
              w_mode_nxt[i] = MODE_OFF;
              w_cnt_nxt[i]  = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
          default: w_led_nxt[i] = 1'b0;
        endcase
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign tick_out  = r_tick;
  assign led_out   = r_led;

endmodule
